// File: rtl/pa_cp0_info_rd_pkg.sv
// Shared definitions for the machine information CSR read path:
// CSR addresses, op encodings, FSM states and decoder output layout.
package pa_cp0_info_rd_pkg;

    localparam int INFO_W_DEF = 32;

    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCPUID    = 12'hFC0;

    typedef enum logic [1:0] {
        OP_RSV = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } info_st_e;

    // One-hot select bit positions
    localparam int SEL_MVENDORID = 0;
    localparam int SEL_MARCHID   = 1;
    localparam int SEL_MIMPID    = 2;
    localparam int SEL_MHARTID   = 3;
    localparam int SEL_MCPUID    = 4;
    localparam int SEL_W         = 5;

    typedef struct packed {
        logic             hit;
        logic             expt;
        logic [SEL_W-1:0] sel;
    } info_dec_t;

    // rs/rc with a zero source performs no write
    function automatic logic csr_wr_intent(input logic [1:0] op, input logic rs1_x0);
        return (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && !rs1_x0);
    endfunction

endpackage

// File: rtl/pa_cp0_info_rd_dec.sv
// Combinational decode of an info-group CSR access: group hit, legality
// and a one-hot register select.
module pa_cp0_info_dec
    import pa_cp0_info_rd_pkg::*;
#(
    parameter logic [11:0] MCPUID_ADDR = CSR_MCPUID
) (
    input  logic [11:0] addr_i,
    input  logic [1:0]  op_i,
    input  logic        priv_m_i,
    input  logic        rs1_x0_i,
    output info_dec_t   dec_o
);

    logic [SEL_W-1:0] sel;
    logic             hit;

    always_comb begin
        sel = '0;
        if (addr_i == CSR_MVENDORID) sel[SEL_MVENDORID] = 1'b1;
        if (addr_i == CSR_MARCHID)   sel[SEL_MARCHID]   = 1'b1;
        if (addr_i == CSR_MIMPID)    sel[SEL_MIMPID]    = 1'b1;
        if (addr_i == CSR_MHARTID)   sel[SEL_MHARTID]   = 1'b1;
        if (addr_i == MCPUID_ADDR)   sel[SEL_MCPUID]    = 1'b1;
    end

    assign hit = |sel;

    // The whole group is machine-mode read-only; op 00 is reserved
    assign dec_o.hit  = hit;
    assign dec_o.expt = hit && (!priv_m_i || csr_wr_intent(op_i, rs1_x0_i) || (op_i == OP_RSV));
    assign dec_o.sel  = sel;

endmodule

// File: rtl/pa_cp0_info_rd.sv
// Read front end for the machine information CSRs: accepts one IU request,
// captures the value, holds the response until ack/flush and pulses retire.
module pa_cp0_info_rd
    import pa_cp0_info_rd_pkg::*;
#(
    parameter logic [11:0] MCPUID_ADDR = CSR_MCPUID,
    parameter int          INFO_W      = INFO_W_DEF
) (
    input  logic              regs_clk,
    input  logic              cpurst_b,
    input  logic              iu_cp0_csr_vld,
    input  logic [11:0]       iu_cp0_csr_addr,
    input  logic [1:0]        iu_cp0_csr_op,
    input  logic              iu_cp0_rs1_x0,
    input  logic              iu_cp0_priv_m,
    input  logic              iu_cp0_rslt_ack,
    input  logic              iu_cp0_flush,
    input  logic [INFO_W-1:0] mvendorid_value,
    input  logic [INFO_W-1:0] marchid_value,
    input  logic [INFO_W-1:0] mimpid_value,
    input  logic [INFO_W-1:0] mhartid_value,
    input  logic [INFO_W-1:0] mcpuid_value,
    output logic              cp0_iu_rdy,
    output logic              cp0_iu_rslt_vld,
    output logic [INFO_W-1:0] cp0_iu_rslt,
    output logic              cp0_iu_hit,
    output logic              cp0_iu_expt,
    output logic              iui_regs_inst_csr,
    output logic              mcpuid_local_en
);

    info_st_e          state_q, state_d;
    logic [INFO_W-1:0] rslt_q, rslt_d;
    logic              hit_q, hit_d;
    logic              expt_q, expt_d;
    logic              mcpuid_q, mcpuid_d;

    info_dec_t         dec;
    logic [INFO_W-1:0] sel_val;
    logic              accept;
    logic              leave;

    pa_cp0_info_dec #(
        .MCPUID_ADDR (MCPUID_ADDR)
    ) u_dec (
        .addr_i   (iu_cp0_csr_addr),
        .op_i     (iu_cp0_csr_op),
        .priv_m_i (iu_cp0_priv_m),
        .rs1_x0_i (iu_cp0_rs1_x0),
        .dec_o    (dec)
    );

    // Excepting or missing accesses return zero data
    always_comb begin
        sel_val = ({INFO_W{dec.sel[SEL_MVENDORID]}} & mvendorid_value)
                | ({INFO_W{dec.sel[SEL_MARCHID]}}   & marchid_value)
                | ({INFO_W{dec.sel[SEL_MIMPID]}}    & mimpid_value)
                | ({INFO_W{dec.sel[SEL_MHARTID]}}   & mhartid_value)
                | ({INFO_W{dec.sel[SEL_MCPUID]}}    & mcpuid_value);
        if (dec.expt) sel_val = '0;
    end

    assign accept = (state_q == ST_IDLE) && iu_cp0_csr_vld && !iu_cp0_flush;
    assign leave  = (state_q == ST_RESP) && (iu_cp0_rslt_ack || iu_cp0_flush);

    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q  <= ST_IDLE;
            rslt_q   <= '0;
            hit_q    <= 1'b0;
            expt_q   <= 1'b0;
            mcpuid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rslt_q   <= rslt_d;
            hit_q    <= hit_d;
            expt_q   <= expt_d;
            mcpuid_q <= mcpuid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (iu_cp0_csr_vld && !iu_cp0_flush) state_d = ST_RESP;
            ST_RESP: if (iu_cp0_rslt_ack || iu_cp0_flush) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Captured fields are frozen through RESP and cleared once the response goes away
    always_comb begin
        rslt_d   = rslt_q;
        hit_d    = hit_q;
        expt_d   = expt_q;
        mcpuid_d = mcpuid_q;
        if (accept) begin
            rslt_d   = sel_val;
            hit_d    = dec.hit;
            expt_d   = dec.expt;
            mcpuid_d = (iu_cp0_csr_addr == MCPUID_ADDR);
        end else if (leave) begin
            rslt_d   = '0;
            hit_d    = 1'b0;
            expt_d   = 1'b0;
            mcpuid_d = 1'b0;
        end
    end

    always_comb begin
        cp0_iu_rdy        = (state_q == ST_IDLE);
        cp0_iu_rslt_vld   = (state_q == ST_RESP);
        cp0_iu_rslt       = rslt_q;
        cp0_iu_hit        = hit_q;
        cp0_iu_expt       = expt_q;
        iui_regs_inst_csr = (state_q == ST_RESP) && iu_cp0_rslt_ack && !iu_cp0_flush
                            && hit_q && !expt_q;
        mcpuid_local_en   = iui_regs_inst_csr && mcpuid_q;
    end

endmodule
